fejkon_pcie_np_ctrl: RTL and testbench
======================================

# fejkon_pcie_np_ctrl

Non-posted request controller between the fejkon PCIe RX request decoder and the BAR0 Avalon-MM read master. It accepts decoded single-DW memory-read requests, issues them one at a time to the BAR0 register space, and pairs in-order read data with saved request context (tag, requester ID, lower address) to produce completions. It caps outstanding reads at the 31 usable tags and throttles the Hard IP through `rx_st_mask` so the request FIFO never overflows.

## Interface
- `AddrWidth`, 12: BAR0 byte-address width.
- `MaxOutstanding`, 31: maximum accepted, uncompleted reads (≤ 31).
- `MaskSlack`, 4: `rx_st_mask` asserts when outstanding ≥ `MaxOutstanding - MaskSlack`.

- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `req_valid` / `req_ready`  in/out  1  request handshake.
- `req_tag`  in  8  PCIe tag.
- `req_requester_id`  in  16  requester ID.
- `req_addr`  in  AddrWidth  DW-aligned byte address.
- `avm_address`  out  AddrWidth  Avalon read address.
- `avm_read`  out  1  Avalon read strobe.
- `avm_waitrequest`  in  1  Avalon stall.
- `avm_readdata`  in  32  read data.
- `avm_readdatavalid`  in  1  read data valid.
- `cpl_valid` / `cpl_ready`  out/in  1  completion handshake.
- `cpl_tag`  out  8; `cpl_requester_id` out 16; `cpl_lower_addr` out 7; `cpl_data` out 32.
- `rx_st_mask`  out  1  NP throttle to Hard IP.
- `outstanding`  out  6  accepted, not-yet-completed reads.
- `err_spurious`  out  1  sticky; readdatavalid with no read pending.
- `stat_reads`  out  32; `stat_hwm`  out  6  statistics (see Configuration).

## Operation
- FSM: IDLE, ISSUE.
- IDLE: `req_ready = (outstanding < MaxOutstanding)`. On accept, latch address, push context {tag, rid, addr[6:0]} into the context FIFO, and go to ISSUE.
- ISSUE: `avm_read = 1` with `avm_address` held stable. While `avm_waitrequest` is high, stay in ISSUE. When it is low, increment `issued_pending` and return to IDLE. `req_ready = 0` in ISSUE.
- `avm_readdatavalid`:
  - If `issued_pending > 0`, push data into the data FIFO and decrement `issued_pending`.
  - Otherwise drop the data and set `err_spurious`, which is cleared only by reset.
- Completion output:
  - `cpl_valid` = data FIFO non-empty. Data FIFO head is paired with context FIFO head.
  - On `cpl_valid & cpl_ready`, pop both FIFOs.
  - Outputs hold stable while `cpl_ready` is low.
- `outstanding` = context FIFO occupancy. Accept and pop in the same cycle leave it unchanged.
- The data FIFO cannot overflow, because the accept limit bounds it.
- `rx_st_mask` is registered: 1 when outstanding ≥ `MaxOutstanding - MaskSlack`, else 0.
- Reset values: `avm_read`=0, `cpl_valid`=0, `rx_st_mask`=0, `outstanding`=0, `err_spurious`=0, stats=0, FSM=IDLE, both FIFOs empty. `req_ready` is 0 during reset.
- Reset mid-operation: all state is discarded. Avalon data arriving after reset counts as spurious. The Avalon slave shares `reset`.

## Timing
- Accept edge to `avm_read` high: 1 cycle.
- `avm_readdatavalid` to `cpl_valid`: 1 cycle.
- Back-to-back accepts: at most one per 2 cycles with zero waitrequest.
- `rx_st_mask` lags the occupancy change by 1 cycle. `MaskSlack` covers Hard IP drain.

## Configuration
- `FEJKON_NP_CTRL_STATS_EN` defined:
  - `stat_reads` counts completions popped, wrapping at 2^32.
  - `stat_hwm` holds the maximum `outstanding` seen since reset.
- Undefined: both ports are tied to 0 and no counter logic is built.

## Structure
- `fejkon_pcie_pkg` holds:
  - `np_ctx_t` struct {tag[7:0], rid[15:0], lower_addr[6:0]}.
  - `NpTagCount = 32`.
  - the FSM state enum.
- Sub-module `fejkon_pcie_np_fifo`: synchronous FIFO with parameters WIDTH and DEPTH (power of two, 32), registered outputs, and count output. It is instantiated twice: context FIFO and data FIFO.

## Test plan
- **Single read.** Read of addr 0x10, tag 3, rid 0x0100; slave returns 0x00000010 after 2 cycles → one completion with tag 3, lower_addr 0x10, data 0x10; `outstanding` returns to 0.
- **Tag exhaustion.** 31 reads (tags 0–30, addr i*4) with readdatavalid withheld → `req_ready` drops after the 31st; `rx_st_mask` high once outstanding reaches 27. On release, completions come out in tag order 0..30 with data i*4.
- **Waitrequest stall.** `avm_waitrequest` held 5 cycles → `avm_read`/`avm_address` stable, exactly one Avalon read, `req_ready` = 0 throughout.
- **Completion backpressure.** `cpl_ready` low 10 cycles with 3 completions buffered → `cpl_tag` head stable, no loss. Accept+pop in the same cycle keeps `outstanding` constant.
- **Spurious data.** readdatavalid with 0 issued → `err_spurious` = 1 and sticky; no `cpl_valid`.
- **Reset mid-operation.** Reset with 5 outstanding → next cycle `outstanding`=0, `cpl_valid`=0, `rx_st_mask`=0, `err_spurious`=0. With `FEJKON_NP_CTRL_STATS_EN` defined, after test 2 expect `stat_reads`=31 and `stat_hwm`=31.

Source files
------------

// File: rtl/fejkon_pcie_pkg.sv
// Shared types for the fejkon PCIe non-posted request path.
`default_nettype none

package fejkon_pcie_pkg;

   localparam int NpTagCount = 32;

   typedef struct packed {
      logic [7:0]  tag;
      logic [15:0] rid;
      logic [6:0]  lower_addr;
   } np_ctx_t;

   typedef enum logic [0:0] {
      NP_IDLE  = 1'b0,
      NP_ISSUE = 1'b1
   } np_state_t;

endpackage

`default_nettype wire

// File: rtl/fejkon_pcie_np_fifo.sv
// Synchronous show-ahead FIFO: dout is a register that always holds the current head entry.
`default_nettype none

module fejkon_pcie_np_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PtrW = $clog2(DEPTH);
   localparam logic [PtrW:0] CountOne  = (PtrW+1)'(1);
   localparam logic [PtrW:0] CountFull = (PtrW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PtrW-1:0]  wr_ptr;
   logic [PtrW-1:0]  rd_ptr;
   logic [PtrW-1:0]  rd_next;
   logic             empty;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign do_push = push & (count != CountFull);
   assign do_pop  = pop & ~empty;
   assign rd_next = rd_ptr + 1'b1;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         dout   <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_next;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // Head comes straight from din when the FIFO is (or is about to be) empty.
         if (empty || (do_pop && count == CountOne)) begin
            if (do_push) begin
               dout <= din;
            end
         end else if (do_pop) begin
            dout <= mem[rd_next];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/fejkon_pcie_np_ctrl.sv
// Non-posted read controller: issues BAR0 reads one at a time and pairs in-order data with saved context.
// Optional statistics counters are built when FEJKON_NP_CTRL_STATS_EN is defined.
`default_nettype none

module fejkon_pcie_np_ctrl
   import fejkon_pcie_pkg::*;
#(
   parameter int AddrWidth      = 12,
   parameter int MaxOutstanding = 31,
   parameter int MaskSlack      = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [7:0]           req_tag,
   input  logic [15:0]          req_requester_id,
   input  logic [AddrWidth-1:0] req_addr,
   output logic [AddrWidth-1:0] avm_address,
   output logic                 avm_read,
   input  logic                 avm_waitrequest,
   input  logic [31:0]          avm_readdata,
   input  logic                 avm_readdatavalid,
   output logic                 cpl_valid,
   input  logic                 cpl_ready,
   output logic [7:0]           cpl_tag,
   output logic [15:0]          cpl_requester_id,
   output logic [6:0]           cpl_lower_addr,
   output logic [31:0]          cpl_data,
   output logic                 rx_st_mask,
   output logic [5:0]           outstanding,
   output logic                 err_spurious,
   output logic [31:0]          stat_reads,
   output logic [5:0]           stat_hwm
);

   localparam logic [5:0] OutLimit  = 6'(MaxOutstanding);
   localparam logic [5:0] MaskLevel = 6'(MaxOutstanding - MaskSlack);

   np_state_t            state;
   np_state_t            state_next;
   logic [AddrWidth-1:0] addr_q;
   logic [5:0]           issued_pending;
   logic [5:0]           data_count;
   np_ctx_t              ctx_in;
   np_ctx_t              ctx_head;
   logic                 can_accept;
   logic                 accept;
   logic                 issue_done;
   logic                 data_push;
   logic                 spurious;
   logic                 cpl_fire;

   assign can_accept = ~reset && (outstanding < OutLimit);
   assign accept     = req_valid & req_ready;
   assign issue_done = avm_read & ~avm_waitrequest;
   assign data_push  = avm_readdatavalid && (issued_pending != '0);
   assign spurious   = avm_readdatavalid && (issued_pending == '0);
   assign cpl_valid  = (data_count != '0);
   assign cpl_fire   = cpl_valid & cpl_ready;

   assign ctx_in.tag        = req_tag;
   assign ctx_in.rid        = req_requester_id;
   assign ctx_in.lower_addr = req_addr[6:0];

   assign avm_address       = addr_q;
   assign cpl_tag           = ctx_head.tag;
   assign cpl_requester_id  = ctx_head.rid;
   assign cpl_lower_addr    = ctx_head.lower_addr;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= NP_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      avm_read   = 1'b0;
      case (state)
         NP_IDLE: begin
            req_ready = can_accept;
            if (req_valid && can_accept) begin
               state_next = NP_ISSUE;
            end
         end
         NP_ISSUE: begin
            avm_read = 1'b1;
            if (!avm_waitrequest) begin
               state_next = NP_IDLE;
            end
         end
         default: state_next = NP_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q         <= '0;
         issued_pending <= '0;
         err_spurious   <= 1'b0;
         rx_st_mask     <= 1'b0;
      end else begin
         if (accept) begin
            addr_q <= req_addr;
         end
         // A read cannot return data in the cycle it is accepted, so both edges may net here.
         issued_pending <= issued_pending + {5'd0, issue_done} - {5'd0, data_push};
         if (spurious) begin
            err_spurious <= 1'b1;
         end
         rx_st_mask <= (outstanding >= MaskLevel);
      end
   end

   fejkon_pcie_np_fifo #(
      .WIDTH ($bits(np_ctx_t)),
      .DEPTH (NpTagCount)
   ) u_ctx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (accept),
      .din   (ctx_in),
      .pop   (cpl_fire),
      .dout  (ctx_head),
      .count (outstanding)
   );

   fejkon_pcie_np_fifo #(
      .WIDTH (32),
      .DEPTH (NpTagCount)
   ) u_data_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (data_push),
      .din   (avm_readdata),
      .pop   (cpl_fire),
      .dout  (cpl_data),
      .count (data_count)
   );

`ifdef FEJKON_NP_CTRL_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_reads <= '0;
         stat_hwm   <= '0;
      end else begin
         if (cpl_fire) begin
            stat_reads <= stat_reads + 32'd1;
         end
         if (outstanding > stat_hwm) begin
            stat_hwm <= outstanding;
         end
      end
   end
`else
   assign stat_reads = '0;
   assign stat_hwm   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fejkon_pcie_np_ctrl.sv
// Directed self-checking bench for fejkon_pcie_np_ctrl.
`default_nettype none

module tb_fejkon_pcie_np_ctrl;

   localparam int AW = 12;
`ifdef FEJKON_NP_CTRL_STATS_EN
   localparam int ExpReads = 31;
   localparam int ExpHwm   = 31;
`else
   localparam int ExpReads = 0;
   localparam int ExpHwm   = 0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic [7:0]    req_tag;
   logic [15:0]   req_requester_id;
   logic [AW-1:0] req_addr;
   logic [AW-1:0] avm_address;
   logic          avm_read;
   logic          avm_waitrequest;
   logic [31:0]   avm_readdata;
   logic          avm_readdatavalid;
   logic          cpl_valid;
   logic          cpl_ready;
   logic [7:0]    cpl_tag;
   logic [15:0]   cpl_requester_id;
   logic [6:0]    cpl_lower_addr;
   logic [31:0]   cpl_data;
   logic          rx_st_mask;
   logic [5:0]    outstanding;
   logic          err_spurious;
   logic [31:0]   stat_reads;
   logic [5:0]    stat_hwm;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fejkon_pcie_np_ctrl #(
      .AddrWidth      (AW),
      .MaxOutstanding (31),
      .MaskSlack      (4)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_tag           (req_tag),
      .req_requester_id  (req_requester_id),
      .req_addr          (req_addr),
      .avm_address       (avm_address),
      .avm_read          (avm_read),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdata      (avm_readdata),
      .avm_readdatavalid (avm_readdatavalid),
      .cpl_valid         (cpl_valid),
      .cpl_ready         (cpl_ready),
      .cpl_tag           (cpl_tag),
      .cpl_requester_id  (cpl_requester_id),
      .cpl_lower_addr    (cpl_lower_addr),
      .cpl_data          (cpl_data),
      .rx_st_mask        (rx_st_mask),
      .outstanding       (outstanding),
      .err_spurious      (err_spurious),
      .stat_reads        (stat_reads),
      .stat_hwm          (stat_hwm)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req_valid         = 1'b0;
      req_tag           = '0;
      req_requester_id  = '0;
      req_addr          = '0;
      avm_waitrequest   = 1'b0;
      avm_readdata      = '0;
      avm_readdatavalid = 1'b0;
      cpl_ready         = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   // Holds a request until accepted; returns just after the accepting edge.
   task automatic send_req(input logic [7:0] tag, input logic [15:0] rid, input logic [AW-1:0] addr);
      bit done = 1'b0;
      req_valid        = 1'b1;
      req_tag          = tag;
      req_requester_id = rid;
      req_addr         = addr;
      for (int n = 0; n < 50 && !done; n++) begin
         if (req_ready) done = 1'b1;
         tick();
      end
      req_valid = 1'b0;
      total++;
      if (!done) begin
         bad++;
         $display("FAIL send_req tag=%0d: req_ready stayed 0, required 1 within 50 cycles", tag);
      end
   endtask

   task automatic return_data(input logic [31:0] d);
      avm_readdata      = d;
      avm_readdatavalid = 1'b1;
      tick();
      avm_readdatavalid = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b1;
      tick();
      tick();
      total++;
      if ({req_ready, avm_read, cpl_valid, rx_st_mask, err_spurious} !== 5'b0) begin
         bad++;
         $display("FAIL reset_flags: got rdy/rd/cv/mask/err=%b, required 00000",
                  {req_ready, avm_read, cpl_valid, rx_st_mask, err_spurious});
      end
      total++;
      if (outstanding !== 6'd0 || stat_reads !== 32'd0 || stat_hwm !== 6'd0) begin
         bad++;
         $display("FAIL reset_counts: got out=%0d reads=%0d hwm=%0d, required 0 0 0",
                  outstanding, stat_reads, stat_hwm);
      end
      reset = 1'b0;
      tick();
      total++;
      if (req_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_release_ready: got %b, required 1", req_ready);
      end
   endtask

   task automatic test_single_read();
      do_reset();
      cpl_ready = 1'b1;
      send_req(8'd3, 16'h0100, 12'h010);
      total++;
      if (avm_read !== 1'b1 || avm_address !== 12'h010 || outstanding !== 6'd1) begin
         bad++;
         $display("FAIL single_issue: got rd=%b addr=%h out=%0d, required 1 010 1",
                  avm_read, avm_address, outstanding);
      end
      tick();
      tick();
      return_data(32'h0000_0010);
      total++;
      if ({cpl_valid, cpl_tag, cpl_requester_id, cpl_lower_addr, cpl_data} !==
          {1'b1, 8'd3, 16'h0100, 7'h10, 32'h0000_0010}) begin
         bad++;
         $display("FAIL single_cpl: got v=%b tag=%0d rid=%h la=%h data=%h, required 1 3 0100 10 00000010",
                  cpl_valid, cpl_tag, cpl_requester_id, cpl_lower_addr, cpl_data);
      end
      tick();
      total++;
      if (cpl_valid !== 1'b0 || outstanding !== 6'd0) begin
         bad++;
         $display("FAIL single_drain: got v=%b out=%0d, required 0 0", cpl_valid, outstanding);
      end
   endtask

   task automatic test_tag_exhaustion();
      logic [7:0]  exp_tag;
      logic [31:0] exp_data;
      logic        exp_mask;
      do_reset();
      for (int i = 0; i < 31; i++) begin
         send_req(8'(i), 16'h0200, 12'(i * 4));
         tick();
         exp_mask = ((i + 1) >= 27);
         total++;
         if (outstanding !== 6'(i + 1) || rx_st_mask !== exp_mask) begin
            bad++;
            $display("FAIL exhaust_fill i=%0d: got out=%0d mask=%b, required %0d %b",
                     i, outstanding, rx_st_mask, i + 1, exp_mask);
         end
      end
      req_valid = 1'b1;
      req_tag   = 8'd31;
      req_addr  = 12'h07C;
      total++;
      if (req_ready !== 1'b0) begin
         bad++;
         $display("FAIL exhaust_ready: got %b, required 0", req_ready);
      end
      tick();
      tick();
      tick();
      req_valid = 1'b0;
      total++;
      if (outstanding !== 6'd31 || avm_read !== 1'b0) begin
         bad++;
         $display("FAIL exhaust_hold: got out=%0d rd=%b, required 31 0", outstanding, avm_read);
      end
      for (int i = 0; i < 31; i++) begin
         return_data(32'(i * 4));
      end
      cpl_ready = 1'b1;
      for (int i = 0; i < 31; i++) begin
         exp_tag  = 8'(i);
         exp_data = 32'(i * 4);
         total++;
         if ({cpl_valid, cpl_tag, cpl_lower_addr, cpl_data} !==
             {1'b1, exp_tag, exp_data[6:0], exp_data}) begin
            bad++;
            $display("FAIL exhaust_order i=%0d: got v=%b tag=%0d la=%h data=%h, required 1 %0d %h %h",
                     i, cpl_valid, cpl_tag, cpl_lower_addr, cpl_data, exp_tag, exp_data[6:0], exp_data);
         end
         tick();
      end
      cpl_ready = 1'b0;
      tick();
      total++;
      if (outstanding !== 6'd0 || cpl_valid !== 1'b0 || rx_st_mask !== 1'b0) begin
         bad++;
         $display("FAIL exhaust_drain: got out=%0d v=%b mask=%b, required 0 0 0",
                  outstanding, cpl_valid, rx_st_mask);
      end
      total++;
      if (stat_reads !== 32'(ExpReads) || stat_hwm !== 6'(ExpHwm)) begin
         bad++;
         $display("FAIL exhaust_stats: got reads=%0d hwm=%0d, required %0d %0d",
                  stat_reads, stat_hwm, ExpReads, ExpHwm);
      end
   endtask

   task automatic test_waitrequest();
      int nreads = 0;
      do_reset();
      avm_waitrequest = 1'b1;
      send_req(8'd5, 16'h0300, 12'h024);
      for (int k = 0; k < 5; k++) begin
         total++;
         if (avm_read !== 1'b1 || avm_address !== 12'h024 || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL stall_hold k=%0d: got rd=%b addr=%h rdy=%b, required 1 024 0",
                     k, avm_read, avm_address, req_ready);
         end
         if (avm_read && !avm_waitrequest) nreads++;
         tick();
      end
      avm_waitrequest = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (avm_read && !avm_waitrequest) nreads++;
         tick();
      end
      total++;
      if (nreads != 1 || outstanding !== 6'd1) begin
         bad++;
         $display("FAIL stall_count: got reads=%0d out=%0d, required 1 1", nreads, outstanding);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         send_req(8'(10 + i), 16'h0400, 12'(12'h040 + i * 4));
         tick();
         return_data(32'(32'hA0 + i));
      end
      for (int k = 0; k < 10; k++) begin
         total++;
         if ({cpl_valid, cpl_tag, cpl_data} !== {1'b1, 8'd10, 32'h0000_00A0}) begin
            bad++;
            $display("FAIL bp_hold k=%0d: got v=%b tag=%0d data=%h, required 1 10 000000a0",
                     k, cpl_valid, cpl_tag, cpl_data);
         end
         tick();
      end
      req_valid        = 1'b1;
      req_tag          = 8'd13;
      req_requester_id = 16'h0400;
      req_addr         = 12'h04C;
      cpl_ready        = 1'b1;
      tick();
      req_valid = 1'b0;
      cpl_ready = 1'b0;
      total++;
      if (outstanding !== 6'd3 || cpl_tag !== 8'd11 || cpl_data !== 32'h0000_00A1 || avm_read !== 1'b1) begin
         bad++;
         $display("FAIL bp_accept_pop: got out=%0d tag=%0d data=%h rd=%b, required 3 11 000000a1 1",
                  outstanding, cpl_tag, cpl_data, avm_read);
      end
      tick();
      return_data(32'h0000_00A3);
      cpl_ready = 1'b1;
      for (int i = 1; i < 4; i++) begin
         total++;
         if ({cpl_valid, cpl_tag, cpl_lower_addr, cpl_data} !==
             {1'b1, 8'(10 + i), 7'(7'h40 + i * 4), 32'(32'hA0 + i)}) begin
            bad++;
            $display("FAIL bp_drain i=%0d: got v=%b tag=%0d la=%h data=%h", i,
                     cpl_valid, cpl_tag, cpl_lower_addr, cpl_data);
         end
         tick();
      end
      total++;
      if (outstanding !== 6'd0 || cpl_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_empty: got out=%0d v=%b, required 0 0", outstanding, cpl_valid);
      end
   endtask

   task automatic test_spurious();
      do_reset();
      cpl_ready = 1'b1;
      return_data(32'h0000_DEAD);
      total++;
      if (err_spurious !== 1'b1 || cpl_valid !== 1'b0) begin
         bad++;
         $display("FAIL spur_set: got err=%b v=%b, required 1 0", err_spurious, cpl_valid);
      end
      tick();
      tick();
      tick();
      total++;
      if (err_spurious !== 1'b1 || cpl_valid !== 1'b0 || outstanding !== 6'd0) begin
         bad++;
         $display("FAIL spur_sticky: got err=%b v=%b out=%0d, required 1 0 0",
                  err_spurious, cpl_valid, outstanding);
      end
   endtask

   task automatic test_reset_midop();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         send_req(8'(20 + i), 16'h0500, 12'(12'h100 + i * 4));
         tick();
      end
      return_data(32'h1234_5678);
      total++;
      if (outstanding !== 6'd5 || cpl_valid !== 1'b1) begin
         bad++;
         $display("FAIL midop_setup: got out=%0d v=%b, required 5 1", outstanding, cpl_valid);
      end
      reset = 1'b1;
      tick();
      total++;
      if ({cpl_valid, rx_st_mask, err_spurious, avm_read} !== 4'b0 || outstanding !== 6'd0) begin
         bad++;
         $display("FAIL midop_reset: got v/mask/err/rd=%b out=%0d, required 0000 0",
                  {cpl_valid, rx_st_mask, err_spurious, avm_read}, outstanding);
      end
      reset = 1'b0;
      tick();
      return_data(32'h0BAD_0BAD);
      total++;
      if (err_spurious !== 1'b1 || cpl_valid !== 1'b0) begin
         bad++;
         $display("FAIL midop_late_data: got err=%b v=%b, required 1 0", err_spurious, cpl_valid);
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_tag_exhaustion();
      test_waitrequest();
      test_backpressure();
      test_spurious();
      test_reset_midop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule

`default_nettype wire
